// File: rtl/max_track8.sv
// Framed signed max tracker: reports the maximum of each WINDOW-sample frame and its position.
// Define MIN_TRACK_EN to also track the frame minimum on min_out.
module max_track8 #(
  parameter int unsigned WINDOW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] max_out,
  output logic [7:0] max_idx,
  output logic [7:0] min_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [7:0] WINDOW_C = 8'(WINDOW);

  state_t     state_r;
  logic [7:0] count_r;
  logic [7:0] max_r;
  logic [7:0] idx_r;
  logic       in_ready_r;
  logic       out_valid_r;
  logic       accept_s;
  logic       last_s;

  // Signed a >= b: opposite signs decide on the sign bit alone, otherwise the low bits order both
  function automatic logic sge(input logic [7:0] a, input logic [7:0] b);
    if (a[7] != b[7]) begin
      sge = b[7];
    end else begin
      sge = (a[6:0] >= b[6:0]);
    end
  endfunction

  // Handshake decode and end-of-frame detect
  always_comb begin
    accept_s = in_valid && in_ready_r;
    last_s   = ((count_r + 8'd1) == WINDOW_C);
  end

  // Frame FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= 8'd0;
      max_r       <= 8'h00;
      idx_r       <= 8'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (clear) begin
      state_r     <= IDLE;
      count_r     <= 8'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          if (accept_s) begin
            max_r   <= in_data;
            idx_r   <= 8'd0;
            count_r <= 8'd1;
            state_r <= ACCUM;
          end else begin
            count_r <= 8'd0;
          end
        end
        ACCUM: begin
          if (accept_s) begin
            count_r <= count_r + 8'd1;
            // >= so that equal samples move the index to the later position
            if (sge(in_data, max_r)) begin
              max_r <= in_data;
              idx_r <= count_r;
            end else begin
              max_r <= max_r;
            end
            if (last_s) begin
              state_r     <= HOLD;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              state_r <= ACCUM;
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_r     <= IDLE;
            count_r     <= 8'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r     <= IDLE;
          count_r     <= 8'd0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef MIN_TRACK_EN
  logic [7:0] min_r;

  // Minimum tracker; <= lets ties follow the same later-position rule as the maximum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_r <= 8'h00;
    end else if (clear) begin
      min_r <= min_r;
    end else if (accept_s && (state_r == IDLE)) begin
      min_r <= in_data;
    end else if (accept_s && (state_r == ACCUM) && sge(min_r, in_data)) begin
      min_r <= in_data;
    end else begin
      min_r <= min_r;
    end
  end

  assign min_out = min_r;
`else
  assign min_out = 8'h00;
`endif

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign max_out   = max_r;
  assign max_idx   = idx_r;

endmodule

// File: tb/tb_max_track8.sv
// Randomized and directed bench for max_track8 against a frame-level reference model.
module tb_max_track8;

  localparam int WINDOW = 4;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] max_out;
  logic [7:0] max_idx;
  logic [7:0] min_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: samples of the frame in progress plus the result being held
  logic [7:0] frame_q[$];
  logic       exp_ready;
  logic       exp_valid;
  logic [7:0] exp_max;
  logic [7:0] exp_idx;
  logic [7:0] exp_min;

  max_track8 #(.WINDOW(WINDOW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .max_out   (max_out),
    .max_idx   (max_idx),
    .min_out   (min_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic void compute_result();
    int best;
    int worst;
    best    = $signed(frame_q[0]);
    worst   = $signed(frame_q[0]);
    exp_idx = 8'd0;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (int'($signed(frame_q[i])) >= best) begin
        best    = $signed(frame_q[i]);
        exp_idx = 8'(i);
      end
      if (int'($signed(frame_q[i])) <= worst) begin
        worst = $signed(frame_q[i]);
      end
    end
    exp_max = 8'(best);
`ifdef MIN_TRACK_EN
    exp_min = 8'(worst);
`else
    exp_min = 8'h00;
`endif
  endfunction

  // One clock: drive, check at negedge, advance model at posedge
  task automatic cycle(input logic v, input logic [7:0] d, input logic ordy, input logic clr);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    @(negedge clk);
    check("in_ready", {7'd0, in_ready}, {7'd0, exp_ready});
    check("out_valid", {7'd0, out_valid}, {7'd0, exp_valid});
    if (exp_valid) begin
      check("max_out", max_out, exp_max);
      check("max_idx", max_idx, exp_idx);
      check("min_out", min_out, exp_min);
    end
`ifndef MIN_TRACK_EN
    else begin
      check("min_tied", min_out, 8'h00);
    end
`endif
    @(posedge clk);
    if (clr) begin
      frame_q.delete();
      exp_valid = 1'b0;
      exp_ready = 1'b1;
    end else if (exp_valid) begin
      if (ordy) begin
        exp_valid = 1'b0;
        exp_ready = 1'b1;
        frame_q.delete();
      end
    end else if (exp_ready && v) begin
      frame_q.push_back(d);
      if (frame_q.size() == WINDOW) begin
        compute_result();
        exp_valid = 1'b1;
        exp_ready = 1'b0;
      end
    end else begin
      exp_ready = 1'b1;
    end
    #1;
  endtask

  task automatic feed4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] e);
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    cycle(1'b1, c, 1'b0, 1'b0);
    cycle(1'b1, e, 1'b0, 1'b0);
  endtask

  task automatic drain();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    exp_ready = 1'b0;
    exp_valid = 1'b0;
    exp_max   = 8'h00;
    exp_idx   = 8'd0;
    exp_min   = 8'h00;
    #2;
    check("rst_in_ready", {7'd0, in_ready}, 8'd0);
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_max_out", max_out, 8'h00);
    check("rst_max_idx", max_idx, 8'h00);
    check("rst_min_out", min_out, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Mixed-sign frame, maximum in the middle
    feed4(8'h05, 8'hFD, 8'h7F, 8'h0A);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("r030_valid", {7'd0, out_valid}, 8'd1);
    check("r030_max", max_out, 8'h7F);
    check("r030_idx", max_idx, 8'd2);

    // Hold the result for ten cycles with upstream still offering data
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'h55, 1'b0, 1'b0);
    end
    check("r032_max_held", max_out, 8'h7F);
    check("r032_ready_held", {7'd0, in_ready}, 8'd0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    check("r032_ready_after", {7'd0, in_ready}, 8'd1);
    check("r032_valid_after", {7'd0, out_valid}, 8'd0);
    drain();

    // All-negative frame with a tie on the maximum
    feed4(8'h80, 8'hFF, 8'hFF, 8'hFE);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("r031_max", max_out, 8'hFF);
    check("r031_idx", max_idx, 8'd2);
`ifdef MIN_TRACK_EN
    check("r031_min", min_out, 8'h80);
`else
    check("r031_min", min_out, 8'h00);
`endif
    drain();

    // Clear part-way through a frame
    cycle(1'b1, 8'h70, 1'b0, 1'b0);
    cycle(1'b1, 8'h71, 1'b0, 1'b0);
    cycle(1'b1, 8'h72, 1'b0, 1'b1);
    feed4(8'h01, 8'h02, 8'h03, 8'h04);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("r033_valid", {7'd0, out_valid}, 8'd1);
    check("r033_max", max_out, 8'h04);
    check("r033_idx", max_idx, 8'd3);
    // Clear while holding drops the result
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_hold_valid", {7'd0, out_valid}, 8'd0);
    drain();

    // Asynchronous reset in the middle of a frame
    cycle(1'b1, 8'h40, 1'b0, 1'b0);
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("r034_valid", {7'd0, out_valid}, 8'd0);
    check("r034_max", max_out, 8'h00);
    check("r034_idx", max_idx, 8'd0);
    check("r034_min", min_out, 8'h00);
    check("r034_ready", {7'd0, in_ready}, 8'd0);
    frame_q.delete();
    exp_valid = 1'b0;
    exp_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 8'h42, 1'b0, 1'b0);
    cycle(1'b1, 8'h43, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("r034_no_result", {7'd0, out_valid}, 8'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) == 0, ($urandom % 50) == 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
